// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lends one uart_tx to N byte-stream clients, one message per grant,
// with a burst cap per grant and an idle gap between grants.
module uart_tx_arbiter #(
    parameter int unsigned channels   = 4,
    parameter int unsigned max_burst  = 16,
    parameter int unsigned gap_cycles = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [channels-1:0]   i_req,
    input  logic [8*channels-1:0] i_data,
    input  logic [channels-1:0]   i_last,
    output logic [channels-1:0]   o_ack,
    output logic [channels-1:0]   o_grant,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_req,
    input  logic                  i_tx_cts,
    output logic                  o_busy,
    output logic [31:0]           o_msg_count
);

    localparam int unsigned IDX_W   = (channels > 1) ? $clog2(channels) : 1;
    localparam int unsigned BURST_W = $clog2(max_burst + 1);
    localparam int unsigned GAP_W   = (gap_cycles > 1) ? $clog2(gap_cycles + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [31:0]          msg_count_q, msg_count_d;

    logic [IDX_W-1:0]     arb_cand;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_found;
    logic [7:0]           own_data;
    logic                 accept;
    logic                 end_grant;

    // Rotating priority: first requester at or after ptr wins.
    always_comb begin
        arb_cand  = '0;
        arb_idx   = ptr_q;
        arb_found = 1'b0;
        for (int unsigned i = 0; i < channels; i++) begin
            arb_cand = IDX_W'((32'(ptr_q) + i) % channels);
            if (!arb_found && i_req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    assign own_data = i_data[{owner_q, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_d     = burst_q;
        gap_d       = gap_q;
        msg_count_d = msg_count_q;
        o_grant     = '0;
        o_ack       = '0;
        o_tx_req    = 1'b0;
        o_tx_data   = '0;
        accept      = 1'b0;
        end_grant   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    owner_d = arb_idx;
                    burst_d = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                o_grant[owner_q] = 1'b1;
                o_tx_req         = i_req[owner_q];
                if (o_tx_req) begin
                    o_tx_data = own_data;
                end
                accept         = o_tx_req & i_tx_cts;
                o_ack[owner_q] = accept;

                // A dropped request abandons the message; a stalled cts just holds.
                if (!i_req[owner_q]) begin
                    end_grant = 1'b1;
                end else if (accept) begin
                    burst_d = burst_q + BURST_W'(1);
                    if (i_last[owner_q]) begin
                        msg_count_d = msg_count_q + 32'd1;
                    end
                    if (i_last[owner_q] || burst_q == BURST_W'(max_burst - 1)) begin
                        end_grant = 1'b1;
                    end
                end

                if (end_grant) begin
                    burst_d = '0;
                    ptr_d   = (owner_q == IDX_W'(channels - 1)) ? '0 : owner_q + IDX_W'(1);
                    if (gap_cycles == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = GAP_W'(gap_cycles - 1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No byte may be handed over while reset is being applied.
        if (!rst_n) begin
            o_grant   = '0;
            o_ack     = '0;
            o_tx_req  = 1'b0;
            o_tx_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_q     <= '0;
            gap_q       <= '0;
            msg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            gap_q       <= gap_d;
            msg_count_q <= msg_count_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_msg_count = msg_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (4 channels, burst 4, gap 2): requester models
// feed byte queues, expected acks are queued at issue time and checked by a monitor.
module tb_uart_tx_arbiter;

    localparam int unsigned CH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     i_req;
    logic [8*CH-1:0]   i_data;
    logic [CH-1:0]     i_last;
    logic [CH-1:0]     o_ack;
    logic [CH-1:0]     o_grant;
    logic [7:0]        o_tx_data;
    logic              o_tx_req;
    logic              i_tx_cts;
    logic              o_busy;
    logic [31:0]       o_msg_count;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [8:0]  src_q[CH][$];
    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned gap_run = 0;

    uart_tx_arbiter #(
        .channels  (4),
        .max_burst (4),
        .gap_cycles(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_tx_data  (o_tx_data),
        .o_tx_req   (o_tx_req),
        .i_tx_cts   (i_tx_cts),
        .o_busy     (o_busy),
        .o_msg_count(o_msg_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present the head of each requester's queue.
    task automatic drive();
        logic [8:0] e;
        for (int n = 0; n < int'(CH); n++) begin
            if (src_q[n].size() != 0) begin
                e = src_q[n][0];
                i_req[n]          = 1'b1;
                i_data[n*8 +: 8]  = e[7:0];
                i_last[n]         = e[8];
            end else begin
                i_req[n]          = 1'b0;
                i_data[n*8 +: 8]  = 8'h00;
                i_last[n]         = 1'b0;
            end
        end
    endtask

    task automatic push_msg(input int ch, input logic [7:0] d, input logic last, input logic expect_ack);
        exp_t e;
        src_q[ch].push_back({last, d});
        if (expect_ack) begin
            e.ch   = 2'(ch);
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    // One clock: note acks, step past the edge, retire acked bytes, re-drive.
    task automatic cyc();
        logic [CH-1:0] a;
        logic [8:0]    dummy;
        @(negedge clk);
        a = o_ack;
        @(posedge clk);
        #1;
        for (int n = 0; n < int'(CH); n++) begin
            if (a[n] && src_q[n].size() != 0) dummy = src_q[n].pop_front();
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int n = 0; n < int'(CH); n++) src_q[n].delete();
        drive();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 200) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
    endtask

    // Monitor: checks every accepted byte and the length of every idle gap.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_busy && o_grant == '0) begin
                gap_run++;
            end else begin
                if (gap_run != 0) chk("gap_len", 32'(gap_run), 32'd2);
                gap_run = 0;
            end
            if (o_ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(o_ack), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_owner", 32'(o_ack), 32'd1 << mon_e.ch);
                    chk("tx_data", 32'(o_tx_data), 32'(mon_e.data));
                    chk("grant_eq_ack", 32'(o_grant), 32'(o_ack));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        i_tx_cts = 1'b1;
        i_req    = '0;
        i_data   = '0;
        i_last   = '0;

        // Reset with every channel requesting, then release.
        for (int n = 0; n < int'(CH); n++) push_msg(n, 8'(8'h10 + n), 1'b1, 1'b1);
        drive();
        cyc();
        cyc();
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_tx_req", 32'(o_tx_req), 32'd0);
        chk("rst_ack", 32'(o_ack), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_count", o_msg_count, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("rel_grant", 32'(o_grant), 32'h1);
        wait_done();
        chk("t1_count", o_msg_count, 32'd4);

        // Single two-byte message.
        do_reset();
        push_msg(0, 8'h41, 1'b0, 1'b1);
        push_msg(0, 8'h42, 1'b1, 1'b1);
        drive();
        wait_done();
        chk("t2_count", o_msg_count, 32'd1);

        // Round robin over 0,1,3 with back-to-back one-byte messages.
        do_reset();
        push_msg(0, 8'hA0, 1'b1, 1'b1);
        push_msg(1, 8'hB0, 1'b1, 1'b1);
        push_msg(3, 8'hD0, 1'b1, 1'b1);
        push_msg(0, 8'hA1, 1'b1, 1'b1);
        push_msg(1, 8'hB1, 1'b1, 1'b1);
        push_msg(3, 8'hD1, 1'b1, 1'b1);
        drive();
        wait_done();
        chk("t3_count", o_msg_count, 32'd6);

        // Burst cap: channel 2 is cut after 4 bytes, channel 1 slips in.
        do_reset();
        for (int k = 0; k < 4; k++) push_msg(2, 8'(8'hC0 + k), 1'b0, 1'b1);
        drive();
        cyc();
        chk("t4_grant2", 32'(o_grant), 32'h4);
        push_msg(1, 8'hB5, 1'b1, 1'b1);
        push_msg(2, 8'hC4, 1'b0, 1'b1);
        push_msg(2, 8'hC5, 1'b1, 1'b1);
        drive();
        wait_done();
        chk("t4_count", o_msg_count, 32'd2);

        // Backpressure holds the grant; dropping the request abandons it.
        do_reset();
        push_msg(0, 8'h50, 1'b0, 1'b1);
        push_msg(0, 8'h51, 1'b0, 1'b0);
        push_msg(0, 8'h52, 1'b0, 1'b0);
        drive();
        cyc();
        cyc();
        i_tx_cts = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_grant", 32'(o_grant), 32'h1);
            chk("stall_ack", 32'(o_ack), 32'd0);
            chk("stall_data", 32'(o_tx_data), 32'h51);
            cyc();
        end
        src_q[0].delete();
        drive();
        i_tx_cts = 1'b1;
        #1;
        chk("abandon_ack", 32'(o_ack), 32'd0);
        chk("abandon_tx_req", 32'(o_tx_req), 32'd0);
        cyc();
        chk("abandon_gap_grant", 32'(o_grant), 32'd0);
        chk("abandon_gap_busy", 32'(o_busy), 32'd1);
        wait_done();
        chk("t5_count", o_msg_count, 32'd0);

        // Reset in the middle of a message.
        do_reset();
        push_msg(0, 8'h60, 1'b0, 1'b1);
        push_msg(0, 8'h61, 1'b1, 1'b0);
        drive();
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", 32'(o_ack), 32'd0);
        chk("rst_mid_tx_req", 32'(o_tx_req), 32'd0);
        cyc();
        src_q[0].delete();
        drive();
        rst_n = 1'b1;
        #1;
        chk("t6_grant", 32'(o_grant), 32'd0);
        chk("t6_tx_req", 32'(o_tx_req), 32'd0);
        chk("t6_tx_data", 32'(o_tx_data), 32'd0);
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_count", o_msg_count, 32'd0);
        cyc();
        chk("t6_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
